// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline stall controller.
// The optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
package cpu_types_pkg;

  localparam int PERF_CNT_W = 16;

  // Code 2'd2 is unused. The controller treats it the same as RUN.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd3
  } pipe_state_t;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard-decision, memory-handshake and stage-control bundle for pipeline_stall_ctrl.
// The counter signals exist only when HAZ_PERF_CNT_EN is defined.
interface pipeline_stall_ctrl_if;
  import cpu_types_pkg::*;

  logic ihit;
  logic dhit;
  logic exmem_dmem_req;
  logic exmem_halt;
  logic lw_nop;
  logic jmp_flush;
  logic brch_flush;

  logic pc_en;
  logic redirect_take;
  logic ifid_en;
  logic ifid_flush;
  logic idex_en;
  logic idex_flush;
  logic exmem_en;
  logic exmem_flush;
  logic memwb_en;
  logic halted;
  logic [1:0] pipe_state;
`ifdef HAZ_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall_cnt;
  logic [PERF_CNT_W-1:0] flush_cnt;
`endif

  modport psc (
    input  ihit, dhit, exmem_dmem_req, exmem_halt, lw_nop, jmp_flush, brch_flush,
    output pc_en, redirect_take, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, halted, pipe_state
`ifdef HAZ_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );

  modport tb (
    output ihit, dhit, exmem_dmem_req, exmem_halt, lw_nop, jmp_flush, brch_flush,
    input  pc_en, redirect_take, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, halted, pipe_state
`ifdef HAZ_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/perf_sat_cnt.sv
// Event counter that stops at its all-ones value.
module perf_sat_cnt
  import cpu_types_pkg::*;
#(
  parameter int W = PERF_CNT_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count events and hold the value once the counter is full.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else if (inc && !(&count_q)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall, flush and redirect control for the PC and the four pipeline latches.
// Defining HAZ_PERF_CNT_EN adds the stall and flush performance counters.
//
// state    | meaning
// ---------+---------------------------------------------------------
// RUN      | normal issue; hazard rules (b)..(g) are evaluated
// MEM_WAIT | data access outstanding; the whole pipe is frozen
// HALTED   | HALT has retired; everything is frozen until RST
module pipeline_stall_ctrl
  import cpu_types_pkg::*;
(
  input logic              CLK,
  input logic              RST,
  pipeline_stall_ctrl_if.psc io
);

  pipe_state_t state_q, state_d;
  logic        squash_q, squash_d;
  logic        halted_q;

  logic pc_en_d, redirect_d;
  logic ifid_en_d, ifid_flush_d;
  logic idex_en_d, idex_flush_d;
  logic exmem_en_d, exmem_flush_d;
  logic memwb_en_d;

  logic mem_stall;
  logic redirect_req;

  assign mem_stall    = io.exmem_dmem_req && !io.dhit;
  assign redirect_req = io.jmp_flush || io.brch_flush;

  // Prioritised stage-control decode. Reset and HALTED freeze every stage.
  always_comb begin
    pc_en_d       = 1'b0;
    redirect_d    = 1'b0;
    ifid_en_d     = 1'b0;
    ifid_flush_d  = 1'b0;
    idex_en_d     = 1'b0;
    idex_flush_d  = 1'b0;
    exmem_en_d    = 1'b0;
    exmem_flush_d = 1'b0;
    memwb_en_d    = 1'b0;
    state_d       = state_q;
    squash_d      = squash_q;

    if (!RST) begin
      case (state_q)
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          if (mem_stall) begin
            state_d = MEM_WAIT;
          end else if (io.exmem_halt) begin
            // Let HALT retire into MEM/WB and leave a bubble in EX/MEM.
            exmem_en_d    = 1'b1;
            exmem_flush_d = 1'b1;
            memwb_en_d    = 1'b1;
            state_d       = HALTED;
          end else begin
            state_d = RUN;
            if (redirect_req) begin
              pc_en_d      = 1'b1;
              redirect_d   = 1'b1;
              ifid_en_d    = 1'b1;
              ifid_flush_d = 1'b1;
              idex_en_d    = 1'b1;
              idex_flush_d = 1'b1;
              exmem_en_d   = 1'b1;
              memwb_en_d   = 1'b1;
              // A wrong-path fetch still in flight must be dropped when it lands.
              // If a squash is already pending it stays pending and applies once.
              squash_d     = squash_q || !io.ihit;
            end else if (io.lw_nop) begin
              idex_en_d    = 1'b1;
              idex_flush_d = 1'b1;
              exmem_en_d   = 1'b1;
              memwb_en_d   = 1'b1;
            end else if (squash_q && io.ihit) begin
              ifid_en_d    = 1'b1;
              ifid_flush_d = 1'b1;
              idex_en_d    = 1'b1;
              exmem_en_d   = 1'b1;
              memwb_en_d   = 1'b1;
              squash_d     = 1'b0;
            end else if (!io.ihit) begin
              ifid_en_d    = 1'b1;
              ifid_flush_d = 1'b1;
              idex_en_d    = 1'b1;
              exmem_en_d   = 1'b1;
              memwb_en_d   = 1'b1;
            end else begin
              pc_en_d      = io.ihit;
              ifid_en_d    = 1'b1;
              idex_en_d    = 1'b1;
              exmem_en_d   = 1'b1;
              memwb_en_d   = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State, squash flag and the sticky halt flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= RUN;
      squash_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      squash_q <= squash_d;
      halted_q <= (state_d == HALTED);
    end
  end

  assign io.pc_en         = pc_en_d;
  assign io.redirect_take = redirect_d;
  assign io.ifid_en       = ifid_en_d;
  assign io.ifid_flush    = ifid_flush_d;
  assign io.idex_en       = idex_en_d;
  assign io.idex_flush    = idex_flush_d;
  assign io.exmem_en      = exmem_en_d;
  assign io.exmem_flush   = exmem_flush_d;
  assign io.memwb_en      = memwb_en_d;
  assign io.halted        = RST ? 1'b0 : halted_q;
  assign io.pipe_state    = RST ? 2'd0 : state_q;

`ifdef HAZ_PERF_CNT_EN
  logic stall_inc;

  assign stall_inc = !RST && (state_q != HALTED) && !pc_en_d;

  perf_sat_cnt #(.W(PERF_CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (stall_inc),
    .count (io.stall_cnt)
  );

  perf_sat_cnt #(.W(PERF_CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (redirect_d),
    .count (io.flush_cnt)
  );
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Consumes the hazard unit's decisions (`lw_nop`, `jmp_flush`, `brch_flush`) together with the memory handshakes (`ihit`, `dhit`). Drives the per-stage enable and flush strobes of the PC and the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB). Holds a small state machine for data-memory waits and processor halt, plus a pending-squash flag for fetches that were in flight when a redirect occurred. Sits in the datapath top between `hazard_unit` and the pipeline registers.

## Interface
- No parameters.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `ihit` in 1: instruction word valid this cycle.
- `dhit` in 1: data access complete this cycle.
- `exmem_dmem_req` in 1: EX/MEM holds a load or store.
- `exmem_halt` in 1: EX/MEM holds HALT.
- `lw_nop` in 1: load-use hazard, from hazard unit.
- `jmp_flush` in 1: jump resolved in EX, from hazard unit.
- `brch_flush` in 1: taken branch resolved in EX, from hazard unit.
- `pc_en` out 1: PC register load.
- `redirect_take` out 1: PC mux selects the EX target.
- `ifid_en`, `ifid_flush` out 1 each.
- `idex_en`, `idex_flush` out 1 each.
- `exmem_en`, `exmem_flush` out 1 each.
- `memwb_en` out 1.
- `halted` out 1: sticky halt.
- `pipe_state` out 2: current `pipe_state_t`.
- `stall_cnt`, `flush_cnt` out 16 each: present only with the macro.

## Operation
- Flush semantics: a latch with `*_flush`=1 loads a NOP on the edge. Flush requires the corresponding `*_en`=1.
- States:
  - RUN=0.
  - MEM_WAIT=1: `exmem_dmem_req` && !`dhit`.
  - HALTED=3.
  - Code 2 is unused and decodes to RUN.
- Flag `squash_pend` (1 bit).
- Priority in RUN/MEM_WAIT, highest first:
  - **(a) Memory stall**, `exmem_dmem_req`&&!`dhit`: all enables 0, all flushes 0, next state MEM_WAIT.
  - **(b) Halt**, `exmem_halt`: `memwb_en`=1, `exmem_flush`=1 (with `exmem_en`=1), other enables 0. Next state HALTED.
  - **(c) Redirect**, `jmp_flush`|`brch_flush`:
    - `pc_en`=1, `redirect_take`=1.
    - `ifid_flush`=1 and `idex_flush`=1, with all enables 1.
    - If !`ihit`, set `squash_pend`.
  - **(d) Load-use**, `lw_nop`: `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `exmem_en`=1, `memwb_en`=1.
  - **(e) Squash**, `squash_pend`&&`ihit`: `pc_en`=0, `ifid_flush`=1, downstream advance. Clear `squash_pend`.
  - **(f) Fetch stall**, !`ihit`: `pc_en`=0, `ifid_flush`=1, downstream advance.
  - **(g) Normal**: all enables 1, `pc_en`=`ihit`.
- MEM_WAIT returns to RUN in the cycle `dhit`=1; that cycle is evaluated by rules (b)–(g).
- HALTED: all enables and flushes 0, `halted`=1. Only `RST` leaves this state.
- `squash_pend` is held, not cleared, during rules (a) and (b).
- A redirect arriving with `squash_pend` already set keeps the flag set; the squash applies once.

## Timing
- Reset values:
  - State RUN, `squash_pend`=0, `halted`=0, counters 0.
  - Outputs during `RST`: every enable and flush 0, `redirect_take`=0, `pipe_state`=0.
- Enable and flush outputs are combinational from the current inputs, state and flag.
- `halted` and `pipe_state` are registered: valid one cycle after the transition edge.
- Redirect latency: target is in the PC after 1 edge; the wrong-path IF/ID and ID/EX slots are NOPs after the same edge.
- `lw_nop` produces exactly one bubble per assertion cycle; the hazard unit deasserts it after the bubble.
- `RST` in any state or mid-stall: the next edge restores reset values.

## Configuration
- `HAZ_PERF_CNT_EN` defined:
  - `stall_cnt` increments each cycle with `pc_en`=0 in RUN/MEM_WAIT.
  - `flush_cnt` increments on each redirect cycle.
  - Both are 16-bit and saturate at 0xFFFF.
- `HAZ_PERF_CNT_EN` undefined: ports and counters are absent.

## Structure
- `cpu_types_pkg`: `pipe_state_t` (2-bit enum RUN, MEM_WAIT, HALTED) and `PERF_CNT_W`=16.
- Interface `pipeline_stall_ctrl_if` with `psc` and `tb` modports.
- Sub-module `perf_sat_cnt`: saturating counter, instantiated twice under the macro.

## Test plan
- **Reset:** assert `RST` mid-MEM_WAIT with `squash_pend`=1 → next cycle state 0, `squash_pend`=0, `halted`=0, counters 0.
- **Load-use:** `lw_nop`=1, `ihit`=1 for 1 cycle → `pc_en`=0, `ifid_en`=0, `idex_flush`=1; PC unchanged; one NOP in ID/EX.
- **Redirect without fetch:** `brch_flush`=1 with `ihit`=0 → `pc_en`=1, `redirect_take`=1, IF/ID and ID/EX flushed. Next `ihit`=1 → `ifid_flush`=1, `pc_en`=0. Following `ihit` → normal load.
- **Memory wait:** `exmem_dmem_req`=1, `dhit`=0 for 3 cycles with `jmp_flush`=1 → all enables 0, `pipe_state`=1. On `dhit`=1 → redirect performed, state back to 0.
- **Halt:** `exmem_halt`=1 → `memwb_en`=1, `exmem_flush`=1 for 1 cycle, then `halted`=1 and every enable 0 for 10 cycles despite `ihit`=1.
- **Counters (with macro):** 70000 fetch-stall cycles → `stall_cnt`=0xFFFF. 3 redirects → `flush_cnt`=3.
